rnn_mem_responder: RTL and testbench



---
 rtl/rnn_mem_responder.sv | 158 +++++++++++++++
 tb/tb_rnn_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rnn_mem_responder
// Purpose  : Six-bank memory responder for the RNN accelerator with host load port.
// Revision : 1.0
// ============================================================================
module rnn_mem_responder #(
  parameter int W         = 20,
  parameter int OUT_AW    = 11,
  parameter int HDR_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mce,
  input  logic [2:0]    msel,
  input  logic [16:0]   maddr,
  input  logic [W-1:0]  mdata_w,
  output logic [W-1:0]  mdata_r,
  input  logic          ld_en,
  input  logic          ld_we,
  input  logic [2:0]    ld_sel,
  input  logic [16:0]   ld_addr,
  input  logic [W-1:0]  ld_wdata,
  output logic [W-1:0]  ld_rdata,
  output logic          ld_rvalid,
  output logic          err,
  input  logic          err_clr,
  output logic [16:0]   wr_count,
  output logic          run_done
);

  localparam int c_HDR_AW = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
  localparam logic [2:0] c_SEL_WIH = 3'b000;
  localparam logic [2:0] c_SEL_BIH = 3'b001;
  localparam logic [2:0] c_SEL_WHH = 3'b010;
  localparam logic [2:0] c_SEL_BHH = 3'b011;
  localparam logic [2:0] c_SEL_HDR = 3'b100;
  localparam logic [2:0] c_SEL_OUT = 3'b101;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  logic [W-1:0] r_wih [0:2047];
  logic [W-1:0] r_bih [0:63];
  logic [W-1:0] r_whh [0:4095];
  logic [W-1:0] r_bhh [0:63];
  logic [W-1:0] r_hdr [0:HDR_DEPTH-1];
  logic [W-1:0] r_out [0:(1<<OUT_AW)-1];

  state_t       r_state;
  logic         r_wrote;

  logic [2:0]   w_sel;
  logic [16:0]  w_addr;
  logic [W-1:0] w_wdata;
  logic         w_access;
  logic         w_we;
  logic         w_in_range;
  logic         w_wr;
  logic         w_host_rd;
  logic         w_acc_rd;
  logic         w_err_set;
  logic [W-1:0] w_rd_data;

  // mce owns the single array port; a host strobe during mce is rejected
  assign w_sel     = mce ? msel    : ld_sel;
  assign w_addr    = mce ? maddr   : ld_addr;
  assign w_wdata   = mce ? mdata_w : ld_wdata;
  assign w_access  = mce | ld_en;
  assign w_we      = mce ? (msel == c_SEL_OUT) : ld_we;
  assign w_wr      = w_access & w_we & w_in_range;
  assign w_host_rd = ld_en & ~mce & ~ld_we;
  assign w_acc_rd  = mce & (msel != c_SEL_OUT);
  assign w_err_set = (ld_en & mce) | (w_access & ~w_in_range);

  always_comb begin
    w_in_range = 1'b0;
    case (w_sel)
      c_SEL_WIH: w_in_range = (w_addr < 17'd2048);
      c_SEL_BIH: w_in_range = (w_addr < 17'd64);
      c_SEL_WHH: w_in_range = (w_addr < 17'd4096);
      c_SEL_BHH: w_in_range = (w_addr < 17'd64);
      c_SEL_HDR: w_in_range = (w_addr < 17'(HDR_DEPTH));
      c_SEL_OUT: w_in_range = ((w_addr >> OUT_AW) == 17'd0);
      default:   w_in_range = 1'b0;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      case (w_sel)
        c_SEL_WIH: w_rd_data = r_wih[w_addr[10:0]];
        c_SEL_BIH: w_rd_data = r_bih[w_addr[5:0]];
        c_SEL_WHH: w_rd_data = r_whh[w_addr[11:0]];
        c_SEL_BHH: w_rd_data = r_bhh[w_addr[5:0]];
        c_SEL_HDR: w_rd_data = r_hdr[w_addr[c_HDR_AW-1:0]];
        c_SEL_OUT: w_rd_data = r_out[w_addr[OUT_AW-1:0]];
        default:   w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      case (w_sel)
        c_SEL_WIH: r_wih[w_addr[10:0]]              <= w_wdata;
        c_SEL_BIH: r_bih[w_addr[5:0]]               <= w_wdata;
        c_SEL_WHH: r_whh[w_addr[11:0]]              <= w_wdata;
        c_SEL_BHH: r_bhh[w_addr[5:0]]               <= w_wdata;
        c_SEL_HDR: r_hdr[w_addr[c_HDR_AW-1:0]]      <= w_wdata;
        c_SEL_OUT: r_out[w_addr[OUT_AW-1:0]]        <= w_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdata_r   <= '0;
      ld_rdata  <= '0;
      ld_rvalid <= 1'b0;
      err       <= 1'b0;
      wr_count  <= '0;
      run_done  <= 1'b0;
      r_state   <= S_IDLE;
      r_wrote   <= 1'b0;
    end else begin
      ld_rvalid <= w_host_rd;
      run_done  <= 1'b0;
      if (w_acc_rd) mdata_r <= w_rd_data;
      if (w_host_rd) ld_rdata <= w_rd_data;
      if (w_err_set) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (w_wr && mce) wr_count <= wr_count + 17'd1;
      // r_wrote covers the entry cycle too, so a write on the first mce cycle counts
      case (r_state)
        S_IDLE: begin
          if (mce) begin
            r_state <= S_ACTIVE;
            r_wrote <= w_wr;
          end
        end
        S_ACTIVE: begin
          if (mce) begin
            r_wrote <= r_wrote | w_wr;
          end else begin
            r_state  <= S_IDLE;
            run_done <= r_wrote;
            r_wrote  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rnn_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rnn_mem_responder
// Purpose  : Randomized self-checking bench with a bank-level reference model.
// Revision : 1.0
// ============================================================================
module tb_rnn_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mce = 1'b0;
  logic [2:0]  msel = '0;
  logic [16:0] maddr = '0;
  logic [19:0] mdata_w = '0;
  logic [19:0] mdata_r;
  logic        ld_en = 1'b0;
  logic        ld_we = 1'b0;
  logic [2:0]  ld_sel = '0;
  logic [16:0] ld_addr = '0;
  logic [19:0] ld_wdata = '0;
  logic [19:0] ld_rdata;
  logic        ld_rvalid;
  logic        err;
  logic        err_clr = 1'b0;
  logic [16:0] wr_count;
  logic        run_done;

  rnn_mem_responder #(.W(20), .OUT_AW(11), .HDR_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mce(mce), .msel(msel), .maddr(maddr),
    .mdata_w(mdata_w), .mdata_r(mdata_r), .ld_en(ld_en), .ld_we(ld_we),
    .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(ld_rdata),
    .ld_rvalid(ld_rvalid), .err(err), .err_clr(err_clr), .wr_count(wr_count),
    .run_done(run_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: six flat banks, run = span of mce high
  logic [19:0] mem [0:6*4096-1];
  logic [19:0] e_mdata = '0, e_ldr = '0;
  logic        e_rvalid = 1'b0, e_err = 1'b0, e_done = 1'b0;
  logic [16:0] e_cnt = '0, cnt_start = '0;
  bit          in_run = 1'b0, m_set;

  function automatic int depth(input logic [2:0] s);
    case (s)
      3'd0: return 2048;
      3'd1: return 64;
      3'd2: return 4096;
      3'd3: return 64;
      3'd4: return 4;
      3'd5: return 2048;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_rng(input logic [2:0] s, input logic [16:0] a);
    return int'(a) < depth(s);
  endfunction

  function automatic int idx(input logic [2:0] s, input logic [16:0] a);
    return int'(s) * 4096 + int'(a);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_mdata = '0; e_ldr = '0; e_rvalid = 1'b0; e_err = 1'b0;
      e_done = 1'b0; e_cnt = '0; in_run = 1'b0;
    end else begin
      m_set = 1'b0; e_rvalid = 1'b0; e_done = 1'b0;
      if (mce) begin
        if (!in_run) begin in_run = 1'b1; cnt_start = e_cnt; end
        if (ld_en) m_set = 1'b1;
        if (msel == 3'd5) begin
          if (in_rng(msel, maddr)) begin mem[idx(msel, maddr)] = mdata_w; e_cnt = e_cnt + 1; end
          else m_set = 1'b1;
        end else if (in_rng(msel, maddr)) e_mdata = mem[idx(msel, maddr)];
        else begin e_mdata = '0; m_set = 1'b1; end
      end else begin
        if (in_run) begin e_done = (e_cnt != cnt_start); in_run = 1'b0; end
        if (ld_en) begin
          if (in_rng(ld_sel, ld_addr)) begin
            if (ld_we) mem[idx(ld_sel, ld_addr)] = ld_wdata;
            else begin e_ldr = mem[idx(ld_sel, ld_addr)]; e_rvalid = 1'b1; end
          end else begin
            m_set = 1'b1;
            if (!ld_we) begin e_ldr = '0; e_rvalid = 1'b1; end
          end
        end
      end
      if (m_set) e_err = 1'b1;
      else if (err_clr) e_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mdata_r", 32'(mdata_r), 32'(e_mdata));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(e_rvalid));
      chk("err", 32'(err), 32'(e_err));
      chk("wr_count", 32'(wr_count), 32'(e_cnt));
      chk("run_done", 32'(run_done), 32'(e_done));
      if (e_rvalid) chk("ld_rdata", 32'(ld_rdata), 32'(e_ldr));
    end
  end

  // ---------------- stimulus helpers
  task automatic tick; @(negedge clk); #1; endtask

  task automatic idle;
    mce = 1'b0; ld_en = 1'b0; ld_we = 1'b0; err_clr = 1'b0; msel = '0; maddr = '0;
  endtask

  task automatic host_wr(input logic [2:0] s, input logic [16:0] a, input logic [19:0] d);
    idle; ld_en = 1'b1; ld_we = 1'b1; ld_sel = s; ld_addr = a; ld_wdata = d; tick; ld_en = 1'b0;
  endtask

  task automatic host_rd(input logic [2:0] s, input logic [16:0] a);
    idle; ld_en = 1'b1; ld_we = 1'b0; ld_sel = s; ld_addr = a; tick; ld_en = 1'b0;
  endtask

  task automatic acc_rd(input logic [2:0] s, input logic [16:0] a);
    idle; mce = 1'b1; msel = s; maddr = a; tick;
  endtask

  task automatic acc_wr(input logic [16:0] a, input logic [19:0] d);
    idle; mce = 1'b1; msel = 3'd5; maddr = a; mdata_w = d; tick;
  endtask

  function automatic logic [16:0] rnd_addr(input logic [2:0] s);
    if (depth(s) == 0 || $urandom_range(0, 15) == 0) return 17'($urandom_range(0, 17'h1FFFF));
    return 17'($urandom_range(0, depth(s) - 1));
  endfunction

  initial begin
    idle;
    repeat (3) tick;
    chk("reset mdata_r", 32'(mdata_r), 32'h0);
    chk("reset wr_count", 32'(wr_count), 32'h0);
    reset = 1'b1;
    chk_on = 1'b1;

    for (int s = 0; s < 6; s++)
      for (int a = 0; a < depth(3'(s)); a++)
        host_wr(3'(s), 17'(a), 20'($urandom));

    // preload then accelerator reads on consecutive cycles
    host_wr(3'd0, 17'h7FF, 20'h80001);
    host_wr(3'd3, 17'd5, 20'hFFFFF);
    acc_rd(3'd0, 17'h7FF);
    chk("lit W_ih[7FF]", 32'(mdata_r), 32'h80001);
    acc_rd(3'd3, 17'd5);
    chk("lit b_hh[5]", 32'(mdata_r), 32'hFFFFF);
    idle; tick;
    chk("lit err clean", 32'(err), 32'h0);
    chk("lit no done on read run", 32'(run_done), 32'h0);

    // output write-back and run_done
    acc_wr(17'h7F, 20'h10000);
    acc_wr(17'h80, 20'hF0000);
    idle; tick;
    chk("lit wr_count 2", 32'(wr_count), 32'd2);
    chk("lit run_done pulse", 32'(run_done), 32'h1);
    tick;
    chk("lit run_done single", 32'(run_done), 32'h0);
    host_rd(3'd5, 17'h7F);
    chk("lit rvalid 7F", 32'(ld_rvalid), 32'h1);
    chk("lit out[7F]", 32'(ld_rdata), 32'h10000);
    host_rd(3'd5, 17'h80);
    chk("lit out[80]", 32'(ld_rdata), 32'hF0000);

    // invalid bank and out-of-range output write
    acc_rd(3'd6, 17'd0);
    chk("lit invalid rd data", 32'(mdata_r), 32'h0);
    chk("lit invalid rd err", 32'(err), 32'h1);
    acc_wr(17'h10000, 20'h12345);
    chk("lit oor wr count", 32'(wr_count), 32'd2);
    idle; err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("lit err_clr", 32'(err), 32'h0);

    // host write while mce high is rejected
    idle; mce = 1'b1; msel = 3'd1; maddr = 17'd0;
    ld_en = 1'b1; ld_we = 1'b1; ld_sel = 3'd0; ld_addr = 17'h7FF; ld_wdata = 20'h12345;
    tick;
    chk("lit busy err", 32'(err), 32'h1);
    chk("lit busy no rvalid", 32'(ld_rvalid), 32'h0);
    idle; err_clr = 1'b1; tick;
    host_rd(3'd0, 17'h7FF);
    chk("lit busy bank kept", 32'(ld_rdata), 32'h80001);

    // read-only run, then header read
    host_wr(3'd4, 17'd0, 20'h00020);
    for (int i = 0; i < 10; i++) acc_rd(3'(i % 4), 17'(i));
    idle; tick;
    chk("lit no done reads only", 32'(run_done), 32'h0);
    acc_rd(3'd4, 17'd0);
    chk("lit header", 32'(mdata_r), 32'h00020);

    // async reset mid-run
    host_wr(3'd2, 17'hFFF, 20'hABCDE);
    acc_rd(3'd7, 17'd0);
    for (int i = 0; i < 4; i++) acc_rd(3'd2, 17'(i));
    #2 reset = 1'b0;
    #1;
    chk("lit rst mdata_r", 32'(mdata_r), 32'h0);
    chk("lit rst wr_count", 32'(wr_count), 32'h0);
    chk("lit rst err", 32'(err), 32'h0);
    idle; tick; tick;
    reset = 1'b1;
    tick;
    acc_rd(3'd2, 17'hFFF);
    chk("lit W_hh[FFF] kept", 32'(mdata_r), 32'hABCDE);
    idle; tick;

    // randomized runs and host gaps
    repeat (150) begin
      for (int i = 0, n = $urandom_range(1, 20); i < n; i++) begin
        int r;
        idle; mce = 1'b1;
        r = $urandom_range(0, 15);
        if (r < 6) msel = 3'd5;
        else if (r == 6) msel = 3'($urandom_range(6, 7));
        else msel = 3'($urandom_range(0, 4));
        maddr = rnd_addr(msel);
        mdata_w = 20'($urandom);
        ld_en = ($urandom_range(0, 19) == 0);
        ld_we = 1'($urandom_range(0, 1));
        err_clr = ($urandom_range(0, 7) == 0);
        tick;
      end
      for (int i = 0, n = $urandom_range(1, 5); i < n; i++) begin
        idle;
        ld_en = ($urandom_range(0, 3) != 0);
        ld_we = 1'($urandom_range(0, 1));
        ld_sel = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        ld_addr = rnd_addr(ld_sel);
        ld_wdata = 20'($urandom);
        err_clr = ($urandom_range(0, 7) == 0);
        tick;
      end
    end
    idle; tick; tick;
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
